// File: rtl/yuv_pkg.sv
// Shared constants, stage record and helpers for the 4:2:2 to 4:4:4 chroma upsampler.
package yuv_pkg;

  localparam int PIX_W = 8;
  localparam logic [PIX_W-1:0] NEUTRAL_C = 8'd128;
  localparam logic MODE_REPLICATE = 1'b0;
  localparam logic MODE_AVERAGE   = 1'b1;

  typedef struct packed {
    logic             de;
    logic             vs;
    logic             phase;
    logic [PIX_W-1:0] y;
    logic [PIX_W-1:0] c;
  } stage_t;

  typedef enum logic [1:0] {
    S_WAIT_LOW  = 2'd0,
    S_WAIT_HIGH = 2'd1,
    S_RUN       = 2'd2
  } state_t;

  // Round-half-up mean of two samples; the 9-bit sum cannot overflow.
  function automatic logic [PIX_W-1:0] avg_round(input logic [PIX_W-1:0] a,
                                                 input logic [PIX_W-1:0] b);
    logic [PIX_W:0] sum;
    sum = {1'b0, a} + {1'b0, b} + {{PIX_W{1'b0}}, 1'b1};
    return sum[PIX_W:1];
  endfunction

endpackage

// File: rtl/yuv_pixel_delay3.sv
// Free-running three-stage pixel delay line; only the de/vs qualifiers are reset.
module yuv_pixel_delay3
  import yuv_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  stage_t stage_in,
  output stage_t tap1,
  output stage_t tap2,
  output stage_t tap3
);

  localparam int DW = 2 * PIX_W + 1;

  logic [2:0]    de_q, de_d, vs_q, vs_d;
  logic [DW-1:0] data_q [3];
  logic [DW-1:0] data_d [3];

  // Next-state of the shift register: every stage moves each clock.
  always_comb begin
    de_d      = {de_q[1:0], stage_in.de};
    vs_d      = {vs_q[1:0], stage_in.vs};
    data_d[0] = {stage_in.phase, stage_in.y, stage_in.c};
    data_d[1] = data_q[0];
    data_d[2] = data_q[1];
  end

  // Qualifier flops, cleared so no stale pixel can look valid after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_q <= 3'b000;
      vs_q <= 3'b000;
    end else begin
      de_q <= de_d;
      vs_q <= vs_d;
    end
  end

  // Payload flops.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  // Tap assembly.
  always_comb begin
    tap1 = {de_q[0], vs_q[0], data_q[0]};
    tap2 = {de_q[1], vs_q[1], data_q[1]};
    tap3 = {de_q[2], vs_q[2], data_q[2]};
  end

endmodule

// File: rtl/yuv422_to_yuv444.sv
// 4:2:2 to 4:4:4 chroma upsampler: frame-aligned start, per-pixel chroma
// regeneration from the neighbouring pixels, fixed 3-clock latency.
module yuv422_to_yuv444
  import yuv_pkg::*;
#(
  parameter logic C_MODE     = MODE_AVERAGE,
  parameter logic C_CB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             per_img_vsync,
  input  logic             per_img_de,
  input  logic [PIX_W-1:0] per_img_y,
  input  logic [PIX_W-1:0] per_img_c,
  output logic             post_img_vsync,
  output logic             post_img_de,
  output logic [PIX_W-1:0] post_img_y,
  output logic [PIX_W-1:0] post_img_cb,
  output logic [PIX_W-1:0] post_img_cr
);

  state_t           state_q, state_d;
  logic             phase_q, phase_d;
  logic             de_q, de_d, vs_q, vs_d;
  logic [PIX_W-1:0] y_q, y_d, cb_q, cb_d, cr_q, cr_d;
  logic             run_s, in_de_s, in_vs_s, own_is_cb_s;
  logic [PIX_W-1:0] other_c_s;
  stage_t           stage_in_s, s1_s, s2_s, s3_s;
  logic             unused_taps_s;

  // Frame-start gating, phase tracking and delay-line input.
  always_comb begin
    run_s   = (state_q == S_RUN) || ((state_q == S_WAIT_HIGH) && per_img_vsync);
    in_de_s = per_img_de & per_img_vsync & run_s;
    in_vs_s = per_img_vsync & run_s;
    phase_d = in_de_s ? ~phase_q : 1'b0;

    state_d = state_q;
    case (state_q)
      S_WAIT_LOW:  if (!per_img_vsync) state_d = S_WAIT_HIGH; else state_d = S_WAIT_LOW;
      S_WAIT_HIGH: if (per_img_vsync)  state_d = S_RUN;       else state_d = S_WAIT_HIGH;
      S_RUN:       state_d = S_RUN;
      default:     state_d = S_WAIT_LOW;
    endcase

    stage_in_s       = '0;
    stage_in_s.de    = in_de_s;
    stage_in_s.vs    = in_vs_s;
    stage_in_s.phase = phase_q;
    stage_in_s.y     = per_img_y;
    stage_in_s.c     = per_img_c;
  end

  yuv_pixel_delay3 u_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .stage_in (stage_in_s),
    .tap1     (s1_s),
    .tap2     (s2_s),
    .tap3     (s3_s)
  );

  // Missing chroma from S3 (left) and S1 (right); de bits keep lines apart.
  always_comb begin
    if ((C_MODE == MODE_AVERAGE) && s3_s.de && s1_s.de) begin
      other_c_s = avg_round(s3_s.c, s1_s.c);
    end else if (s1_s.de) begin
      other_c_s = s1_s.c;
    end else if (s3_s.de) begin
      other_c_s = s3_s.c;
    end else begin
      other_c_s = NEUTRAL_C;
    end

    own_is_cb_s = (s2_s.phase != C_CB_FIRST);
    de_d        = s2_s.de;
    vs_d        = s2_s.vs;

    if (s2_s.de) begin
      y_d  = s2_s.y;
      cb_d = own_is_cb_s ? s2_s.c : other_c_s;
      cr_d = own_is_cb_s ? other_c_s : s2_s.c;
    end else begin
      y_d  = y_q;
      cb_d = cb_q;
      cr_d = cr_q;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WAIT_LOW;
      phase_q <= 1'b0;
      de_q    <= 1'b0;
      vs_q    <= 1'b0;
      y_q     <= 8'd0;
      cb_q    <= 8'd0;
      cr_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      de_q    <= de_d;
      vs_q    <= vs_d;
      y_q     <= y_d;
      cb_q    <= cb_d;
      cr_q    <= cr_d;
    end
  end

  assign post_img_de    = de_q;
  assign post_img_vsync = vs_q;
  assign post_img_y     = y_q;
  assign post_img_cb    = cb_q;
  assign post_img_cr    = cr_q;

  assign unused_taps_s = ^{s1_s.vs, s1_s.phase, s1_s.y, s3_s.vs, s3_s.phase, s3_s.y};

endmodule

// File: tb/tb_yuv422_to_yuv444.sv
// Scoreboard bench: three configurations (average/Cb-first, replicate/Cb-first, average/Cr-first).
`timescale 1ns/1ps
module tb_yuv422_to_yuv444;
  import yuv_pkg::*;

  typedef struct {
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
    int         due;
  } exp_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync = 1'b0;
  logic       de    = 1'b0;
  logic [7:0] yin   = 8'd0;
  logic [7:0] cin   = 8'd0;

  logic       post_vs [3];
  logic       post_de [3];
  logic [7:0] post_y  [3];
  logic [7:0] post_cb [3];
  logic [7:0] post_cr [3];

  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   de_seen = 0;
  exp_t sb_q [3][$];
  logic [7:0] line_y [16];
  logic [7:0] line_c [16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    yuv422_to_yuv444 #(
      .C_MODE     ((g == 1) ? MODE_REPLICATE : MODE_AVERAGE),
      .C_CB_FIRST ((g == 2) ? 1'b0 : 1'b1)
    ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .per_img_vsync  (vsync),
      .per_img_de     (de),
      .per_img_y      (yin),
      .per_img_c      (cin),
      .post_img_vsync (post_vs[g]),
      .post_img_de    (post_de[g]),
      .post_img_y     (post_y[g]),
      .post_img_cb    (post_cb[g]),
      .post_img_cr    (post_cr[g])
    );
  end

  // Reference: instance 1 replicates, others average; instance 2 has Cr on even pixels.
  function automatic void model_px(input int k, input int i, input int n,
                                   output logic [7:0] cb, output logic [7:0] cr);
    logic [7:0] other;
    logic [8:0] sum;
    bit left, right, own_cb;
    left  = (i > 0);
    right = (i < n - 1);
    if (k != 1 && left && right) begin
      sum   = {1'b0, line_c[i-1]} + {1'b0, line_c[i+1]} + 9'd1;
      other = sum[8:1];
    end else if (right) other = line_c[i+1];
    else if (left) other = line_c[i-1];
    else other = 8'd128;
    own_cb = (((i % 2) == 0) == (k != 2));
    cb = own_cb ? line_c[i] : other;
    cr = own_cb ? other : line_c[i];
  endfunction

  task automatic tick(input int n = 1);
    for (int t = 0; t < n; t++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_px(input int i, input int n);
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      model_px(k, i, n, e.cb, e.cr);
      e.y   = line_y[i];
      e.due = cyc + 3;
      sb_q[k].push_back(e);
    end
  endtask

  task automatic drive_line(input int n, input bit expect_out);
    for (int i = 0; i < n; i++) begin
      if (expect_out) push_px(i, n);
      de = 1'b1; yin = line_y[i]; cin = line_c[i];
      tick();
    end
    de = 1'b0;
    tick();
  endtask

  task automatic drain(input string name);
    tick(6);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (sb_q[k].size() !== 0)
        $display("FAIL %s_drain inst%0d: %0d outputs still missing, required 0", name, k, sb_q[k].size());
      else passes++;
      sb_q[k].delete();
    end
  endtask

  task automatic check_zero(input string name);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({post_vs[k], post_de[k], post_y[k], post_cb[k], post_cr[k]} !== 27'd0)
        $display("FAIL %s inst%0d: vs=%b de=%b y=%0d cb=%0d cr=%0d, required all 0",
                 name, k, post_vs[k], post_de[k], post_y[k], post_cb[k], post_cr[k]);
      else passes++;
    end
  endtask

  task automatic frame_start();
    vsync = 1'b0; tick(2);
    vsync = 1'b1; tick(2);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vsync = 1'b1; tick(3);
    check_zero("reset_state");
    rst_n = 1'b1; tick(2);
  endtask

  task automatic test_no_partial_frame();
    de_seen = 0;
    for (int i = 0; i < 4; i++) begin line_y[i] = 8'(90 + i); line_c[i] = 8'(60 + i); end
    drive_line(4, 1'b0);
    tick(5);
    checks++;
    if (de_seen !== 0) $display("FAIL partial_frame: %0d de cycles, required 0", de_seen);
    else passes++;
    frame_start();
  endtask

  task automatic test_avg_line();
    for (int i = 0; i < 4; i++) begin line_y[i] = 8'(16 + i); line_c[i] = 8'(10 * (i + 1)); end
    drive_line(4, 1'b1);
    drain("line4");
  endtask

  task automatic test_odd_and_single();
    line_y[0] = 8'd5; line_y[1] = 8'd6; line_y[2] = 8'd7;
    line_c[0] = 8'd100; line_c[1] = 8'd50; line_c[2] = 8'd200;
    drive_line(3, 1'b1);
    line_y[0] = 8'd9; line_c[0] = 8'd77;
    drive_line(1, 1'b1);
    drain("odd_single");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin line_y[i] = 8'(200 + i); line_c[i] = 8'(250 - i); end
    drive_line(4, 1'b1);
    for (int i = 0; i < 4; i++) begin line_y[i] = 8'(30 + i); line_c[i] = 8'(i + 1); end
    drive_line(4, 1'b1);
    drain("back_to_back");
  endtask

  task automatic test_random_lines();
    for (int l = 0; l < 5; l++) begin
      int n;
      n = $urandom_range(12, 1);
      for (int i = 0; i < n; i++) begin
        line_y[i] = 8'($urandom_range(255, 0));
        line_c[i] = (l == 0) ? 8'd255 : 8'($urandom_range(255, 0));
      end
      drive_line(n, 1'b1);
    end
    drain("random");
  endtask

  task automatic test_vsync_drop();
    for (int i = 0; i < 4; i++) begin line_y[i] = 8'(70 + i); line_c[i] = 8'(3 + 40 * i); end
    for (int i = 0; i < 4; i++) begin
      if (i < 2) push_px(i, 2);
      vsync = (i < 2); de = 1'b1; yin = line_y[i]; cin = line_c[i];
      tick();
    end
    de = 1'b0;
    drain("vsync_drop");
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (post_vs[k] !== 1'b0) $display("FAIL vsync_low inst%0d: vs=%b, required 0", k, post_vs[k]);
      else passes++;
    end
    vsync = 1'b1; tick(2);
  endtask

  task automatic test_reset_mid_line();
    for (int i = 0; i < 4; i++) begin line_y[i] = 8'(111 + i); line_c[i] = 8'(21 + i); end
    for (int i = 0; i < 3; i++) begin
      de = 1'b1; yin = line_y[i]; cin = line_c[i];
      if (i < 2) tick();
    end
    #2 rst_n = 1'b0;
    #1 check_zero("reset_mid_line");
    tick();
    rst_n = 1'b1; yin = line_y[3]; cin = line_c[3];
    tick();
    de = 1'b0; tick();
    de_seen = 0;
    drive_line(4, 1'b0);
    tick(5);
    checks++;
    if (de_seen !== 0) $display("FAIL after_reset_output: %0d de cycles, required 0", de_seen);
    else passes++;
    frame_start();
    drive_line(4, 1'b1);
    drain("after_reset");
  endtask

  // Scoreboard: every output pixel is popped and checked for value and exact cycle.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (post_de[k] === 1'b1) begin
          de_seen++;
          if (sb_q[k].size() == 0) begin
            checks++;
            $display("FAIL unexpected_de inst%0d cyc=%0d: y=%0d, required no output", k, cyc, post_y[k]);
          end else begin
            exp_t e;
            e = sb_q[k].pop_front();
            checks++;
            if (post_y[k] !== e.y || post_cb[k] !== e.cb || post_cr[k] !== e.cr || cyc !== e.due)
              $display("FAIL pixel inst%0d: cyc=%0d y=%0d cb=%0d cr=%0d, required cyc=%0d y=%0d cb=%0d cr=%0d",
                       k, cyc, post_y[k], post_cb[k], post_cr[k], e.due, e.y, e.cb, e.cr);
            else passes++;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_no_partial_frame();
    test_avg_line();
    test_odd_and_single();
    test_back_to_back();
    test_random_lines();
    test_vsync_drop();
    test_reset_mid_line();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
